// File: rtl/cim_xbar_tile_if.sv
// Host-side bus of the compute-in-memory crossbar tile:
// input/weight write ports, MVM start/status and result read port.
interface cim_xbar_tile_if #(
    parameter int xbar_size     = 128,
    parameter int datatype_size = 2
);
    localparam int AW = $clog2(xbar_size);

    logic                     i_wr_en;
    logic [AW-1:0]            i_cim_wr_addr;
    logic [datatype_size-1:0] i_cim_data;
    logic                     i_w_we;
    logic [AW-1:0]            i_w_row;
    logic [AW-1:0]            i_w_col;
    logic [datatype_size-1:0] i_w_data;
    logic                     i_start;
    logic                     o_busy;
    logic                     o_done;
    logic [AW-1:0]            i_cim_rd_addr;
    logic [datatype_size-1:0] o_data;

    modport master (
        output i_wr_en, i_cim_wr_addr, i_cim_data,
        output i_w_we, i_w_row, i_w_col, i_w_data,
        output i_start, i_cim_rd_addr,
        input  o_busy, o_done, o_data
    );

    modport slave (
        input  i_wr_en, i_cim_wr_addr, i_cim_data,
        input  i_w_we, i_w_row, i_w_col, i_w_data,
        input  i_start, i_cim_rd_addr,
        output o_busy, o_done, o_data
    );
endinterface

// File: rtl/cim_xbar_tile.sv
// Crossbar MVM tile: one weight row per COMPUTE cycle accumulated into all
// columns in parallel, then saturated into the output registers in DONE.
module cim_xbar_tile #(
    parameter int xbar_size     = 128,
    parameter int datatype_size = 2
) (
    input logic            clk,
    input logic            rst,
    cim_xbar_tile_if.slave bus
);
    localparam int AW   = $clog2(xbar_size);
    localparam int DW   = datatype_size;
    localparam int ACCW = 2 * DW + AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam logic [AW-1:0] ROW_LAST = AW'(xbar_size - 1);
    localparam logic [DW-1:0] DMAX     = '1;

    logic [1:0]      state_q, state_d;
    logic [AW-1:0]   row_q, row_d;
    logic [DW-1:0]   o_data_q, o_data_d;
    logic [ACCW-1:0] acc_q [xbar_size];
    logic [ACCW-1:0] acc_d [xbar_size];
    logic [DW-1:0]   out_q [xbar_size];
    logic [DW-1:0]   out_d [xbar_size];
    logic [DW-1:0]   in_q  [xbar_size];
    logic [DW-1:0]   w_q   [xbar_size][xbar_size];
    logic            in_we;
    logic            w_we;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        acc_d    = acc_q;
        out_d    = out_q;
        in_we    = 1'b0;
        w_we     = 1'b0;
        o_data_d = out_q[bus.i_cim_rd_addr];
        unique case (state_q)
            S_IDLE: begin
                // A write coinciding with start lands before the first row is read
                in_we = bus.i_wr_en;
                w_we  = bus.i_w_we;
                if (bus.i_start) begin
                    state_d = S_COMPUTE;
                    row_d   = '0;
                    for (int c = 0; c < xbar_size; c++) acc_d[c] = '0;
                end
            end
            S_COMPUTE: begin
                for (int c = 0; c < xbar_size; c++) begin
                    acc_d[c] = acc_q[c]
                             + ACCW'(in_q[row_q]) * ACCW'(w_q[row_q][c]);
                end
                row_d = row_q + 1'b1;
                if (row_q == ROW_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                for (int c = 0; c < xbar_size; c++) begin
                    out_d[c] = (acc_q[c] > ACCW'(DMAX)) ? DMAX
                                                        : acc_q[c][DW-1:0];
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            o_data_q <= '0;
            for (int c = 0; c < xbar_size; c++) begin
                acc_q[c] <= '0;
                out_q[c] <= '0;
                in_q[c]  <= '0;
                for (int r = 0; r < xbar_size; r++) w_q[r][c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            o_data_q <= o_data_d;
            acc_q    <= acc_d;
            out_q    <= out_d;
            if (in_we) in_q[bus.i_cim_wr_addr] <= bus.i_cim_data;
            if (w_we) w_q[bus.i_w_row][bus.i_w_col] <= bus.i_w_data;
        end
    end

    assign bus.o_busy = (state_q != S_IDLE);
    assign bus.o_done = (state_q == S_DONE);
    assign bus.o_data = o_data_q;
endmodule

// File: tb/tb_cim_xbar_tile.sv
// Directed bench for cim_xbar_tile at 128x128, 2-bit data.
module tb_cim_xbar_tile;
    localparam int N = 128;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int busy_cyc, done_cnt, done_last, bad;

    always #5 clk = ~clk;

    cim_xbar_tile_if #(.xbar_size(N), .datatype_size(D)) bus ();

    cim_xbar_tile #(.xbar_size(N), .datatype_size(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_w(input int r, input int c, input int d);
        bus.i_w_we   = 1'b1;
        bus.i_w_row  = 7'(r);
        bus.i_w_col  = 7'(c);
        bus.i_w_data = 2'(d);
        step();
        bus.i_w_we = 1'b0;
    endtask

    task automatic wr_in(input int a, input int d);
        bus.i_wr_en       = 1'b1;
        bus.i_cim_wr_addr = 7'(a);
        bus.i_cim_data    = 2'(d);
        step();
        bus.i_wr_en = 1'b0;
    endtask

    task automatic rd(input int a, output int v);
        bus.i_cim_rd_addr = 7'(a);
        step();
        v = int'(bus.o_data);
    endtask

    // Pulse start; optionally inject a start+writes at busy cycle inj,
    // and count busy cycles whose o_data differs from mon_val.
    task automatic run_mvm(input int inj, input bit mon, input int mon_val,
                           output int nb, output int nd, output int dl,
                           output int nbad);
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_w_we  = 1'b0;
        nb = 0; nd = 0; dl = 0; nbad = 0;
        for (int k = 0; k < 400 && bus.o_busy; k++) begin
            nb++;
            if (bus.o_done) nd++;
            dl = int'(bus.o_done);
            if (mon && int'(bus.o_data) != mon_val) nbad++;
            if (k == inj) begin
                bus.i_start       = 1'b1;
                bus.i_wr_en       = 1'b1;
                bus.i_cim_wr_addr = 7'd1;
                bus.i_cim_data    = 2'd3;
                bus.i_w_we        = 1'b1;
                bus.i_w_row       = 7'd1;
                bus.i_w_col       = 7'd5;
                bus.i_w_data      = 2'd1;
            end else begin
                bus.i_start = 1'b0;
                bus.i_wr_en = 1'b0;
                bus.i_w_we  = 1'b0;
            end
            step();
        end
        bus.i_start = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_w_we  = 1'b0;
    endtask

    initial begin
        int v;
        bus.i_wr_en       = 1'b0;
        bus.i_cim_wr_addr = '0;
        bus.i_cim_data    = '0;
        bus.i_w_we        = 1'b0;
        bus.i_w_row       = '0;
        bus.i_w_col       = '0;
        bus.i_w_data      = '0;
        bus.i_start       = 1'b0;
        bus.i_cim_rd_addr = '0;

        #3;
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_done", int'(bus.o_done), 0);
        chk("rst_data", int'(bus.o_data), 0);
        step();
        rst = 1'b0;
        rd(0, v);
        chk("idle_read0", v, 0);

        // All ones: every column sums to 128, saturating to 3
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                bus.i_wr_en       = (c == 0);
                bus.i_cim_wr_addr = 7'(r);
                bus.i_cim_data    = 2'd1;
                bus.i_w_we        = 1'b1;
                bus.i_w_row       = 7'(r);
                bus.i_w_col       = 7'(c);
                bus.i_w_data      = 2'd1;
                step();
            end
        end
        bus.i_wr_en = 1'b0;
        bus.i_w_we  = 1'b0;
        run_mvm(-1, 0, 0, busy_cyc, done_cnt, done_last, bad);
        chk("ones_busy_len", busy_cyc, 129);
        chk("ones_done_cnt", done_cnt, 1);
        chk("ones_done_last", done_last, 1);
        chk("ones_done_low", int'(bus.o_done), 0);
        rd(0, v);   chk("ones_col0", v, 3);
        rd(64, v);  chk("ones_col64", v, 3);
        rd(127, v); chk("ones_col127", v, 3);

        // Single product: in[0]=2, w[0][5]=1
        #2 rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
        wr_in(0, 2);
        wr_w(0, 5, 1);
        run_mvm(-1, 0, 0, busy_cyc, done_cnt, done_last, bad);
        chk("single_busy_len", busy_cyc, 129);
        rd(4, v); chk("single_col4", v, 0);
        bus.i_cim_rd_addr = 7'd5;
        #2;
        chk("single_pre_edge", int'(bus.o_data), 0);
        step();
        chk("single_col5", int'(bus.o_data), 2);
        rd(6, v); chk("single_col6", v, 0);

        // Start and writes during busy must be ignored
        run_mvm(10, 0, 0, busy_cyc, done_cnt, done_last, bad);
        chk("restart_busy_len", busy_cyc, 129);
        chk("restart_done_cnt", done_cnt, 1);
        chk("restart_idle_after", int'(bus.o_busy), 0);
        rd(5, v); chk("restart_col5", v, 2);
        run_mvm(-1, 0, 0, busy_cyc, done_cnt, done_last, bad);
        rd(5, v); chk("persist_col5", v, 2);

        // Read during MVM returns the previous result
        wr_in(0, 1);
        bus.i_cim_rd_addr = 7'd5;
        step();
        run_mvm(-1, 1, 2, busy_cyc, done_cnt, done_last, bad);
        chk("busy_read_old", bad, 0);
        step();
        chk("new_result_col5", int'(bus.o_data), 1);

        // Reset at COMPUTE row 60
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        for (int k = 0; k < 60; k++) step();
        chk("mid_busy", int'(bus.o_busy), 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", int'(bus.o_busy), 0);
        chk("arst_done", int'(bus.o_done), 0);
        chk("arst_data", int'(bus.o_data), 0);
        step();
        rst = 1'b0;
        run_mvm(-1, 0, 0, busy_cyc, done_cnt, done_last, bad);
        chk("post_rst_busy_len", busy_cyc, 129);
        chk("post_rst_done_cnt", done_cnt, 1);
        rd(5, v); chk("post_rst_col5", v, 0);
        rd(0, v); chk("post_rst_col0", v, 0);

        // Write coinciding with start is used by the MVM
        wr_w(127, 0, 1);
        bus.i_wr_en       = 1'b1;
        bus.i_cim_wr_addr = 7'd127;
        bus.i_cim_data    = 2'd3;
        run_mvm(-1, 0, 0, busy_cyc, done_cnt, done_last, bad);
        chk("same_cyc_busy_len", busy_cyc, 129);
        rd(0, v); chk("same_cyc_col0", v, 3);
        rd(1, v); chk("same_cyc_col1", v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
